bin2bcd_serial_param: RTL and testbench

Parametrised sequential binary-to-BCD converter that uses the shift/add-3 (double-dabble) method. It is the generalised successor of the fixed 10-bit, 4-digit converter. It adds configurable input width and digit count, a start/busy/done handshake, optional signed input, overflow saturation, a leading-zero blanking mask and an optional free-running mode. It sits between measurement datapaths and the 7-segment/display and serial-report formatters.

---
 rtl/bin2bcd_serial_param.sv | 149 ++++++++++++++
 tb/tb_bin2bcd_serial_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_serial_param.sv
// Sequential shift/add-3 binary-to-BCD converter with start/busy/done handshake,
// optional signed input, overflow saturation and leading-zero digit mask.
module bin2bcd_serial_param #(
  parameter int unsigned BIN_W       = 10,
  parameter int unsigned DIGITS      = 4,
  parameter bit          SIGNED_MODE = 1'b0,
  parameter bit          CONTINUOUS  = 1'b0
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iCE,
  input  logic                  iStart,
  input  logic [BIN_W-1:0]      ivBinary,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [4*DIGITS-1:0]   ovBCD,
  output logic [DIGITS-1:0]     ovDigitValid,
  output logic                  oSign,
  output logic                  oOverflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned SH_W  = BCD_W + BIN_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_lat_q, sign_lat_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]  valid_q, valid_d;
  logic               sign_q, sign_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [BCD_W-1:0]   adj_c;
  logic [SH_W-1:0]    shift_c;
  logic               any_c;
  int unsigned        idx_c;

  // Next-state: add-3 correction, joint shift of {digits, magnitude}, completion.
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    dig_d      = dig_q;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;
    sign_lat_d = sign_lat_q;
    bcd_d      = bcd_q;
    valid_d    = valid_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;
    done_d     = done_q;
    adj_c      = '0;
    shift_c    = '0;
    any_c      = 1'b0;
    idx_c      = 0;

    for (int unsigned i = 0; i < DIGITS; i++) begin
      adj_c[4*i +: 4] = (dig_q[4*i +: 4] >= 4'd5) ? (dig_q[4*i +: 4] + 4'd3) : dig_q[4*i +: 4];
    end
    shift_c = {adj_c, mag_q, 1'b0};

    case (state_q)
      IDLE, DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
        if (CONTINUOUS || iStart) begin
          mag_d      = (SIGNED_MODE && ivBinary[BIN_W-1]) ? (~ivBinary + BIN_W'(1)) : ivBinary;
          sign_lat_d = SIGNED_MODE & ivBinary[BIN_W-1];
          dig_d      = '0;
          sticky_d   = 1'b0;
          cnt_d      = CNT_W'(BIN_W);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        mag_d    = shift_c[BIN_W-1:0];
        dig_d    = shift_c[SH_W-2:BIN_W];
        sticky_d = sticky_q | shift_c[SH_W-1];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          ovf_d   = sticky_d;
          bcd_d   = sticky_d ? {DIGITS{4'h9}} : dig_d;
          // Mask scans from the top digit down; overflow forces every digit visible.
          for (int unsigned j = 0; j < DIGITS; j++) begin
            idx_c          = DIGITS - 1 - j;
            any_c          = any_c | sticky_d | (|dig_d[4*idx_c +: 4]);
            valid_d[idx_c] = any_c;
          end
          valid_d[0] = 1'b1;
          sign_d     = sign_lat_q & (sticky_d | (|dig_d));
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      dig_q      <= '0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
      sign_lat_q <= 1'b0;
      bcd_q      <= '0;
      valid_q    <= DIGITS'(1);
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (iCE) begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      dig_q      <= dig_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
      sign_lat_q <= sign_lat_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign oBusy        = busy_q;
  assign oDone        = done_q;
  assign ovBCD        = bcd_q;
  assign ovDigitValid = valid_q;
  assign oSign        = sign_q;
  assign oOverflow    = ovf_q;

endmodule

// File: tb/tb_bin2bcd_serial_param.sv
// Scoreboard bench: four converter configurations checked against a decimal
// reference model; expectations are queued at stimulus time and popped on oDone.
module tb_bin2bcd_serial_param;

  typedef struct packed {
    logic [31:0] bcd;
    logic [7:0]  mask;
    logic        sign;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: divide/modulo on the magnitude, no double-dabble.
  function automatic exp_t model(input longint v, input int bw, input int nd, input bit sm);
    exp_t   e;
    longint mag, lim, t;
    bit     seen;
    e   = '0;
    mag = v & ((64'sd1 <<< bw) - 1);
    if (sm && (((mag >> (bw - 1)) & 1) == 1)) begin
      mag    = (64'sd1 <<< bw) - mag;
      e.sign = 1'b1;
    end
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (mag >= lim) begin
      e.ovf = 1'b1;
      for (int i = 0; i < nd; i++) begin
        e.bcd[4*i +: 4] = 4'h9;
        e.mask[i]       = 1'b1;
      end
    end else begin
      t = mag;
      for (int i = 0; i < nd; i++) begin
        e.bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      seen = 1'b0;
      for (int i = nd - 1; i >= 0; i--) begin
        if (e.bcd[4*i +: 4] != 4'h0) seen = 1'b1;
        e.mask[i] = seen;
      end
      e.mask[0] = 1'b1;
    end
    if (mag == 0) e.sign = 1'b0;
    return e;
  endfunction

  task automatic score(input string pfx, input exp_t e, input logic [31:0] bcd,
                       input logic [7:0] dv, input logic sign, input logic ovf);
    check_val({pfx, "_bcd"},  64'(bcd),  64'(e.bcd));
    check_val({pfx, "_mask"}, 64'(dv),   64'(e.mask));
    check_val({pfx, "_sign"}, 64'(sign), 64'(e.sign));
    check_val({pfx, "_ovf"},  64'(ovf),  64'(e.ovf));
  endtask

  logic rst_n, rst_a;
  logic ce_a, one;
  logic start_a, start_b, start_c, zero;
  logic [9:0]  bin_a, bin_c, bin_d;
  logic [13:0] bin_b;

  logic busy_a, done_a, sign_a, ovf_a; logic [15:0] bcd_a; logic [3:0] dv_a;
  logic busy_b, done_b, sign_b, ovf_b; logic [15:0] bcd_b; logic [3:0] dv_b;
  logic busy_c, done_c, sign_c, ovf_c; logic [15:0] bcd_c; logic [3:0] dv_c;
  logic busy_d, done_d, sign_d, ovf_d; logic [15:0] bcd_d; logic [3:0] dv_d;

  bin2bcd_serial_param u_a (
    .iClk(clk), .iReset_n(rst_a), .iCE(ce_a), .iStart(start_a), .ivBinary(bin_a),
    .oBusy(busy_a), .oDone(done_a), .ovBCD(bcd_a), .ovDigitValid(dv_a),
    .oSign(sign_a), .oOverflow(ovf_a));

  bin2bcd_serial_param #(.BIN_W(14), .DIGITS(4)) u_b (
    .iClk(clk), .iReset_n(rst_n), .iCE(one), .iStart(start_b), .ivBinary(bin_b),
    .oBusy(busy_b), .oDone(done_b), .ovBCD(bcd_b), .ovDigitValid(dv_b),
    .oSign(sign_b), .oOverflow(ovf_b));

  bin2bcd_serial_param #(.BIN_W(10), .DIGITS(4), .SIGNED_MODE(1'b1)) u_c (
    .iClk(clk), .iReset_n(rst_n), .iCE(one), .iStart(start_c), .ivBinary(bin_c),
    .oBusy(busy_c), .oDone(done_c), .ovBCD(bcd_c), .ovDigitValid(dv_c),
    .oSign(sign_c), .oOverflow(ovf_c));

  bin2bcd_serial_param #(.BIN_W(10), .DIGITS(4), .CONTINUOUS(1'b1)) u_d (
    .iClk(clk), .iReset_n(rst_n), .iCE(one), .iStart(zero), .ivBinary(bin_d),
    .oBusy(busy_d), .oDone(done_d), .ovBCD(bcd_d), .ovDigitValid(dv_d),
    .oSign(sign_d), .oOverflow(ovf_d));

  exp_t q_a[$], q_b[$], q_c[$], q_d[$];
  int   ecnt_a = 0, snap_a = 0, done_edge_a = 0, busy_cnt_a = 0;
  logic ce_q_a = 1'b0;
  int   cyc_d = 0, last_d = -1, done_cnt_d = 0;

  // Enabled-edge counter for u_a; an oDone level only counts after an enabled edge.
  always @(posedge clk) begin
    ce_q_a <= ce_a;
    if (ce_a && rst_a) ecnt_a <= ecnt_a + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_a) begin
      busy_cnt_a = 0;
    end else if (ce_q_a) begin
      if (busy_a) busy_cnt_a++;
      if (done_a) begin
        done_edge_a = ecnt_a;
        if (q_a.size() == 0) check_val("a_spurious_done", 64'd1, 64'd0);
        else begin
          e = q_a.pop_front();
          score("a", e, 32'(bcd_a), 8'(dv_a), sign_a, ovf_a);
          check_val("a_busy_cycles", 64'(busy_cnt_a), 64'd10);
        end
        busy_cnt_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_b) begin
      if (q_b.size() == 0) check_val("b_spurious_done", 64'd1, 64'd0);
      else begin e = q_b.pop_front(); score("b", e, 32'(bcd_b), 8'(dv_b), sign_b, ovf_b); end
    end
    if (rst_n && done_c) begin
      if (q_c.size() == 0) check_val("c_spurious_done", 64'd1, 64'd0);
      else begin e = q_c.pop_front(); score("c", e, 32'(bcd_c), 8'(dv_c), sign_c, ovf_c); end
    end
  end

  // Free-running instance accepts on the first edge out of reset, then every 11 edges.
  always @(posedge clk) begin
    if (rst_n) begin
      if (cyc_d % 11 == 0) q_d.push_back(model(longint'(bin_d), 10, 4, 1'b0));
      cyc_d <= cyc_d + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_d) begin
      if (q_d.size() == 0) check_val("d_spurious_done", 64'd1, 64'd0);
      else begin e = q_d.pop_front(); score("d", e, 32'(bcd_d), 8'(dv_d), sign_d, ovf_d); end
      if (last_d >= 0) check_val("d_done_gap", 64'(cyc_d - last_d), 64'd11);
      last_d <= cyc_d;
      done_cnt_d <= done_cnt_d + 1;
    end
  end

  initial begin
    bin_d = 10'd0;
    forever begin
      @(negedge clk);
      if (rst_n) bin_d = bin_d + 10'd37;
    end
  end

  task automatic start_conv(input int which, input longint v);
    case (which)
      0: begin bin_a = 10'(v); start_a = 1'b1; ce_a = 1'b1; snap_a = ecnt_a;
               q_a.push_back(model(v, 10, 4, 1'b0)); end
      1: begin bin_b = 14'(v); start_b = 1'b1; q_b.push_back(model(v, 14, 4, 1'b0)); end
      default: begin bin_c = 10'(v); start_c = 1'b1; q_c.push_back(model(v, 10, 4, 1'b1)); end
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bin_a = ~bin_a; bin_b = ~bin_b; bin_c = ~bin_c;
  endtask

  task automatic wait_done(input string tag, input int which, input int budget, input bit toggle_ce);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      case (which)
        0:       seen = done_a;
        1:       seen = done_b;
        default: seen = done_c;
      endcase
      if (toggle_ce && !seen) ce_a = 1'($urandom_range(0, 1));
    end
    #1;
    ce_a = 1'b1;
    if (!seen) check_val({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int first_edge;
    rst_n = 1'b0; rst_a = 1'b0; ce_a = 1'b1; one = 1'b1; zero = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bin_a = '0; bin_b = '0; bin_c = '0;
    #12;
    check_val("rst_busy", 64'(busy_a), 64'd0);
    check_val("rst_done", 64'(done_a), 64'd0);
    check_val("rst_bcd",  64'(bcd_a),  64'd0);
    check_val("rst_mask", 64'(dv_a),   64'd1);
    check_val("rst_sign", 64'(sign_c), 64'd0);
    check_val("rst_ovf",  64'(ovf_a),  64'd0);
    @(negedge clk);
    rst_n = 1'b1; rst_a = 1'b1;
    @(negedge clk);

    start_conv(0, 1023);
    wait_done("a_1023", 0, 40, 1'b0);
    check_val("a_latency", 64'(done_edge_a - (snap_a + 1)), 64'd10);

    start_conv(0, 0);
    wait_done("a_zero", 0, 40, 1'b0);
    first_edge = done_edge_a;
    start_conv(0, 7);
    wait_done("a_seven", 0, 40, 1'b0);
    check_val("a_b2b_gap", 64'(done_edge_a - first_edge), 64'd11);

    start_conv(0, 1023);
    wait_done("a_ce_toggle", 0, 200, 1'b1);
    check_val("a_ce_latency", 64'(done_edge_a - (snap_a + 1)), 64'd10);

    start_conv(0, 500);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start_a = (k % 2 == 0);
      bin_a   = 10'd999;
    end
    wait_done("a_start_ignored", 0, 40, 1'b0);
    check_val("a_ignored_latency", 64'(done_edge_a - (snap_a + 1)), 64'd10);

    start_conv(0, 1023);
    repeat (5) @(negedge clk);
    #2 rst_a = 1'b0;
    #1;
    check_val("arst_busy", 64'(busy_a), 64'd0);
    check_val("arst_done", 64'(done_a), 64'd0);
    check_val("arst_bcd",  64'(bcd_a),  64'd0);
    check_val("arst_mask", 64'(dv_a),   64'd1);
    check_val("arst_ovf",  64'(ovf_a),  64'd0);
    q_a.delete();
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    repeat (30) @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      start_conv(0, longint'($urandom_range(0, 1023)));
      wait_done("a_rand", 0, 40, 1'b0);
    end

    start_conv(1, 12345); wait_done("b_12345", 1, 40, 1'b0);
    start_conv(1, 9999);  wait_done("b_9999",  1, 40, 1'b0);
    start_conv(1, 10000); wait_done("b_10000", 1, 40, 1'b0);
    start_conv(1, 0);     wait_done("b_0",     1, 40, 1'b0);

    start_conv(2, -512);  wait_done("c_m512",  2, 40, 1'b0);
    start_conv(2, -1);    wait_done("c_m1",    2, 40, 1'b0);
    start_conv(2, 0);     wait_done("c_0",     2, 40, 1'b0);
    start_conv(2, 511);   wait_done("c_511",   2, 40, 1'b0);

    repeat (20) @(negedge clk);
    check_val("a_queue_empty", 64'(q_a.size()), 64'd0);
    check_val("b_queue_empty", 64'(q_b.size()), 64'd0);
    check_val("c_queue_empty", 64'(q_c.size()), 64'd0);
    check_val("d_progress", 64'(done_cnt_d >= 10), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
